// File: rtl/cfa_pkg.sv
// Shared types and helpers for the CFA window front-end.
package cfa_pkg;

  localparam int PIX_W = 12;
  localparam int WIN_N = 5;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN
  } cfa_state_e;

  // Flat tap position of e{i}t{j}, i = row (1 = top), j = column (1 = left).
  function automatic int tap_idx(input int i, input int j);
    return WIN_N * (i - 1) + (j - 1);
  endfunction

  // Bits needed to hold a coordinate in 0..n-1 (never less than one bit).
  function automatic int coord_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cfa_line_buf.sv
// Four-line history RAM: combinational read, synchronous write at the same address.
module cfa_line_buf #(
  parameter int DEPTH = 640,
  parameter int DW    = 48
) (
  input  logic                                clk,
  input  logic                                we,
  input  logic [cfa_pkg::coord_w(DEPTH)-1:0]  addr,
  input  logic [DW-1:0]                       din,
  output logic [DW-1:0]                       dout
);
  import cfa_pkg::*;

  logic [DW-1:0] mem [DEPTH];

  // Storage is deliberately not reset; every line is rewritten before it is used.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

  assign dout = mem[addr];

endmodule

// File: rtl/cfa_window_ctrl.sv
// Raster-to-5x5 window sequencer for the CFA gradient unit, with result re-alignment.
module cfa_window_ctrl #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int PIX_W    = cfa_pkg::PIX_W,
  parameter int GRAD_LAT = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               sof,
  input  logic                               pix_valid,
  input  logic [PIX_W-1:0]                   pix,
  output logic [25*PIX_W-1:0]                win,
  output logic                               start,
  output logic [cfa_pkg::coord_w(IMG_H)-1:0] cen_row,
  output logic [cfa_pkg::coord_w(IMG_W)-1:0] cen_col,
  input  logic [7:0]                         grad_hs_i,
  input  logic [7:0]                         grad_vs_i,
  output logic                               grad_valid,
  output logic [7:0]                         grad_hs,
  output logic [7:0]                         grad_vs,
  output logic [cfa_pkg::coord_w(IMG_H)-1:0] grad_row,
  output logic [cfa_pkg::coord_w(IMG_W)-1:0] grad_col,
  output logic                               busy,
  output logic                               frame_done,
  output logic                               frame_err
);
  import cfa_pkg::*;

  localparam int RW = coord_w(IMG_H);
  localparam int CW = coord_w(IMG_W);
  localparam int DW = coord_w(GRAD_LAT + 1);
  localparam int LW = 4 * PIX_W;

  cfa_state_e                 state_q, state_d;
  logic [DW-1:0]              drain_cnt_q;
  logic [RW-1:0]              row_q, acc_row;
  logic [CW-1:0]              col_q, acc_col;
  logic                       accept, restart, last_pix, drain_end;
  logic [LW-1:0]              lb_rd;
  logic [4:0][4:0][PIX_W-1:0] cols_q;
  logic                       vld_p [GRAD_LAT];
  logic [RW-1:0]              row_p [GRAD_LAT];
  logic [CW-1:0]              col_p [GRAD_LAT];

  // A sof pixel always becomes (0,0); in IDLE only sof pixels are taken, in DRAIN none.
  assign accept   = pix_valid && (((state_q == IDLE) && sof) || (state_q == ACTIVE));
  assign restart  = pix_valid && sof && (state_q == ACTIVE);
  assign acc_row  = sof ? '0 : row_q;
  assign acc_col  = sof ? '0 : col_q;
  assign last_pix = accept && (acc_row == RW'(IMG_H - 1)) && (acc_col == CW'(IMG_W - 1));

  cfa_line_buf #(
    .DEPTH (IMG_W),
    .DW    (LW)
  ) u_line_buf (
    .clk  (clk),
    .we   (accept),
    .addr (acc_col),
    .din  ({lb_rd[3*PIX_W-1:0], pix}),
    .dout (lb_rd)
  );

  // FSM state register and drain cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= ((state_q == DRAIN) && !drain_end) ? drain_cnt_q + DW'(1) : '0;
    end
  end

  // Next state plus status outputs; DRAIN lasts GRAD_LAT+1 cycles.
  always_comb begin
    state_d    = state_q;
    drain_end  = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE:    if (accept) state_d = ACTIVE;
      ACTIVE: begin
        busy = 1'b1;
        if (last_pix) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt_q == DW'(GRAD_LAT)) begin
          drain_end  = 1'b1;
          frame_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q <= '0;
      col_q <= '0;
    end else if (accept) begin
      if (acc_col == CW'(IMG_W - 1)) begin
        col_q <= '0;
        row_q <= acc_row + RW'(1);
      end else begin
        col_q <= acc_col + CW'(1);
        row_q <= acc_row;
      end
    end
  end

  // Window columns shift left; new right column is l3 (top) .. pix (bottom).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cols_q <= '0;
    end else if (accept) begin
      cols_q[3:0] <= cols_q[4:1];
      cols_q[4]   <= {pix, lb_rd[PIX_W-1:0], lb_rd[2*PIX_W-1:PIX_W],
                      lb_rd[3*PIX_W-1:2*PIX_W], lb_rd[4*PIX_W-1:3*PIX_W]};
    end
  end

  // Start fires only once the window holds five real rows and five same-line columns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start   <= 1'b0;
      cen_row <= '0;
      cen_col <= '0;
    end else begin
      start <= accept && (acc_row >= RW'(4)) && (acc_col >= CW'(4));
      if (accept && (acc_row >= RW'(4)) && (acc_col >= CW'(4))) begin
        cen_row <= acc_row - RW'(2);
        cen_col <= acc_col - CW'(2);
      end
    end
  end

  // Sticky error on a mid-frame sof; a completed frame clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            frame_err <= 1'b0;
    else if (restart)    frame_err <= 1'b1;
    else if (frame_done) frame_err <= 1'b0;
  end

  // p0..pN: start and centre delayed to match the gradient unit latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < GRAD_LAT; k++) begin
        vld_p[k] <= 1'b0;
        row_p[k] <= '0;
        col_p[k] <= '0;
      end
    end else begin
      vld_p[0] <= start;
      row_p[0] <= cen_row;
      col_p[0] <= cen_col;
      for (int k = 1; k < GRAD_LAT; k++) begin
        vld_p[k] <= vld_p[k-1];
        row_p[k] <= row_p[k-1];
        col_p[k] <= col_p[k-1];
      end
    end
  end

  // Output stage: capture gradients together with their centre coordinates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grad_valid <= 1'b0;
      grad_hs    <= '0;
      grad_vs    <= '0;
      grad_row   <= '0;
      grad_col   <= '0;
    end else begin
      grad_valid <= vld_p[GRAD_LAT-1];
      if (vld_p[GRAD_LAT-1]) begin
        grad_hs  <= grad_hs_i;
        grad_vs  <= grad_vs_i;
        grad_row <= row_p[GRAD_LAT-1];
        grad_col <= col_p[GRAD_LAT-1];
      end
    end
  end

  // Flatten column-major window registers into the e{i}t{j} tap bus.
  always_comb begin
    win = '0;
    for (int i = 1; i <= 5; i++)
      for (int j = 1; j <= 5; j++)
        win[tap_idx(i, j)*PIX_W +: PIX_W] = cols_q[j-1][i-1];
  end

endmodule

// File: tb/tb_cfa_window_ctrl.sv
// Bench for cfa_window_ctrl on an 8x6 frame with a frame-level reference model.
module tb_cfa_window_ctrl;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int GL = 2;
  localparam int PW = 12;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            sof = 1'b0;
  logic            pix_valid = 1'b0;
  logic [PW-1:0]   pix = '0;
  logic [25*PW-1:0] win;
  logic            start;
  logic [2:0]      cen_row, cen_col, grad_row, grad_col;
  logic [7:0]      grad_hs_i, grad_vs_i, grad_hs, grad_vs;
  logic            grad_valid, busy, frame_done, frame_err;

  cfa_window_ctrl #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .GRAD_LAT(GL)) dut (
    .clk(clk), .rst(rst), .sof(sof), .pix_valid(pix_valid), .pix(pix),
    .win(win), .start(start), .cen_row(cen_row), .cen_col(cen_col),
    .grad_hs_i(grad_hs_i), .grad_vs_i(grad_vs_i), .grad_valid(grad_valid),
    .grad_hs(grad_hs), .grad_vs(grad_vs), .grad_row(grad_row), .grad_col(grad_col),
    .busy(busy), .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in gradient unit: hs = centre tap, vs = top-left tap, GL cycles after start.
  logic [7:0] hist_hs [GL];
  logic [7:0] hist_vs [GL];
  always @(posedge clk) begin
    hist_hs[0] <= win[12*PW +: 8];
    hist_vs[0] <= win[0 +: 8];
    for (int k = 1; k < GL; k++) begin
      hist_hs[k] <= hist_hs[k-1];
      hist_vs[k] <= hist_vs[k-1];
    end
  end
  assign grad_hs_i = hist_hs[GL-1];
  assign grad_vs_i = hist_vs[GL-1];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [299:0] act, input logic [299:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Frame-level reference model.
  typedef struct { int cyc; int r; int c; logic [25*PW-1:0] w; } st_t;
  typedef struct { int cyc; int r; int c; logic [7:0] hs; logic [7:0] vs; } gv_t;
  st_t exp_st[$];
  gv_t exp_gv[$];
  int  exp_fd[$];
  logic [PW-1:0] img [H][W];
  int  m_mode = 0;        // 0 idle, 1 in frame, 2 draining
  int  m_drain_until = 0;
  int  m_r = 0, m_c = 0;
  bit  m_busy_now = 0;
  bit  m_err_set = 0;
  bit  exp_err = 0;
  bit  model_on = 0;

  task automatic step(input bit v, input bit s, input logic [PW-1:0] p);
    st_t e;
    gv_t g;
    if (m_mode == 2 && cyc > m_drain_until) m_mode = 0;
    m_busy_now = (m_mode != 0);
    if (v && s && m_mode == 1) m_err_set = 1;
    if (v && ((m_mode == 0 && s) || m_mode == 1)) begin
      if (s) begin m_r = 0; m_c = 0; end
      img[m_r][m_c] = p;
      if (m_r >= 4 && m_c >= 4) begin
        e.cyc = cyc + 1; e.r = m_r - 2; e.c = m_c - 2; e.w = '0;
        for (int i = 1; i <= 5; i++)
          for (int j = 1; j <= 5; j++)
            e.w[((i-1)*5 + (j-1))*PW +: PW] = img[m_r-5+i][m_c-5+j];
        exp_st.push_back(e);
        g.cyc = cyc + GL + 2; g.r = m_r - 2; g.c = m_c - 2;
        g.hs = img[m_r-2][m_c-2][7:0];
        g.vs = img[m_r-4][m_c-4][7:0];
        exp_gv.push_back(g);
      end
      if (m_r == H-1 && m_c == W-1) begin
        m_mode = 2;
        m_drain_until = cyc + GL + 1;
        exp_fd.push_back(cyc + GL + 1);
      end else begin
        m_mode = 1;
      end
      if (m_c == W-1) begin m_c = 0; m_r++; end
      else m_c++;
    end
  endtask

  // Observed results, for literal pins.
  int obs_cr[$], obs_cc[$], obs_e11[$], obs_e33[$], obs_e55[$];
  int obs_gh[$], obs_gr[$], obs_gc[$];
  int n_fd = 0;
  bit w_st, w_gv, w_fd;
  st_t cur_st;
  gv_t cur_gv;

  always @(negedge clk) begin
    if (model_on) begin
      w_st = (exp_st.size() > 0) && (exp_st[0].cyc == cyc);
      chk("start", start, w_st);
      if (start) begin
        obs_cr.push_back(cen_row); obs_cc.push_back(cen_col);
        obs_e11.push_back(win[0 +: PW]); obs_e33.push_back(win[12*PW +: PW]);
        obs_e55.push_back(win[24*PW +: PW]);
      end
      if (w_st) begin
        cur_st = exp_st.pop_front();
        chk("cen_row", cen_row, cur_st.r);
        chk("cen_col", cen_col, cur_st.c);
        chk("win", win, cur_st.w);
      end
      w_gv = (exp_gv.size() > 0) && (exp_gv[0].cyc == cyc);
      chk("grad_valid", grad_valid, w_gv);
      if (grad_valid) begin
        obs_gh.push_back(grad_hs); obs_gr.push_back(grad_row); obs_gc.push_back(grad_col);
      end
      if (w_gv) begin
        cur_gv = exp_gv.pop_front();
        chk("grad_hs", grad_hs, cur_gv.hs);
        chk("grad_vs", grad_vs, cur_gv.vs);
        chk("grad_row", grad_row, cur_gv.r);
        chk("grad_col", grad_col, cur_gv.c);
      end
      w_fd = (exp_fd.size() > 0) && (exp_fd[0] == cyc);
      chk("frame_done", frame_done, w_fd);
      if (frame_done) n_fd++;
      if (w_fd) void'(exp_fd.pop_front());
      chk("busy", busy, m_busy_now);
      chk("frame_err", frame_err, exp_err);
      if (m_err_set) exp_err = 1;
      if (w_fd) exp_err = 0;
      m_err_set = 0;
    end
  end

  task automatic cyc_drive(input bit v, input bit s, input logic [PW-1:0] p);
    @(posedge clk); #1;
    pix_valid = v; sof = s; pix = p;
    step(v, s, p);
  endtask

  // Sends raster indices lo..hi-1 (pixel = {row,col} nibbles), gap idle cycles after each.
  task automatic send_range(input int gap, input int lo, input int hi);
    for (int k = lo; k < hi; k++) begin
      cyc_drive(1'b1, k == 0, PW'(((k / W) << 4) | (k % W)));
      repeat (gap) cyc_drive(1'b0, 1'b0, '0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cyc_drive(1'b0, 1'b0, '0);
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst = 1'b1; pix_valid = 1'b0; sof = 1'b0;
    m_mode = 0; m_busy_now = 0; m_err_set = 0; exp_err = 0;
    model_on = 1;
  endtask

  // Literal expectations for a complete 8x6 frame of {row,col} pixels.
  task automatic check_frame(input string tag, input int sb, input int gb, input int fb);
    chk({tag, "_nstart"}, obs_cr.size() - sb, 8);
    chk({tag, "_ngrad"}, obs_gh.size() - gb, 8);
    chk({tag, "_nfd"}, n_fd - fb, 1);
    if (obs_cr.size() >= sb + 8) begin
      chk({tag, "_first_cen_row"}, obs_cr[sb], 2);
      chk({tag, "_first_cen_col"}, obs_cc[sb], 2);
      chk({tag, "_first_e1t1"}, obs_e11[sb], 12'h000);
      chk({tag, "_first_e3t3"}, obs_e33[sb], 12'h022);
      chk({tag, "_first_e5t5"}, obs_e55[sb], 12'h044);
      chk({tag, "_last_cen_row"}, obs_cr[sb+7], 3);
      chk({tag, "_last_cen_col"}, obs_cc[sb+7], 5);
    end
    if (obs_gh.size() > gb) begin
      chk({tag, "_first_grad_hs"}, obs_gh[gb], 8'h22);
      chk({tag, "_first_grad_row"}, obs_gr[gb], 2);
      chk({tag, "_first_grad_col"}, obs_gc[gb], 2);
    end
  endtask

  int sb, gb, fb;

  initial begin
    // Reset held with activity on the pixel inputs.
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      pix_valid = k[0]; sof = 1'b1; pix = 12'h0AB;
      @(negedge clk);
      chk("rst_start", start, 0);
      chk("rst_grad_valid", grad_valid, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_win", win, 0);
      chk("rst_cen", {cen_row, cen_col}, 0);
    end
    release_reset();
    idle(3);

    // Continuous frame.
    sb = obs_cr.size(); gb = obs_gh.size(); fb = n_fd;
    send_range(0, 0, W*H);
    idle(8);
    check_frame("contig", sb, gb, fb);

    // Same frame, pixel every third cycle.
    sb = obs_cr.size(); gb = obs_gh.size(); fb = n_fd;
    send_range(2, 0, W*H);
    idle(8);
    check_frame("gapped", sb, gb, fb);

    // Frame aborted by sof at position (3,2), followed by a full frame.
    sb = obs_cr.size(); gb = obs_gh.size(); fb = n_fd;
    send_range(0, 0, 3*W + 2);
    send_range(0, 0, 2);
    chk("abort_err_set", frame_err, 1);
    send_range(0, 2, W*H);
    idle(8);
    check_frame("restart", sb, gb, fb);
    chk("abort_err_cleared", frame_err, 0);

    // Pixels without sof while idle are ignored.
    sb = obs_cr.size();
    for (int k = 0; k < 10; k++) cyc_drive(1'b1, 1'b0, PW'(k));
    chk("idle_nostart", obs_cr.size() - sb, 0);
    chk("idle_busy", busy, 0);
    idle(2);

    // Reset pulse in row 4 with results still in flight.
    send_range(0, 0, 4*W + 6);
    idle(1);
    @(posedge clk); #1;
    model_on = 0;
    rst = 1'b0;
    exp_st.delete(); exp_gv.delete(); exp_fd.delete();
    #1;
    chk("midrst_start", start, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_win", win, 0);
    repeat (2) @(posedge clk);
    release_reset();
    sb = obs_cr.size(); gb = obs_gh.size(); fb = n_fd;
    for (int k = 0; k < 20; k++) cyc_drive(1'b1, 1'b0, PW'(k));
    idle(4);
    chk("midrst_nstart", obs_cr.size() - sb, 0);
    chk("midrst_ngrad", obs_gh.size() - gb, 0);
    chk("midrst_nfd", n_fd - fb, 0);

    chk("pending_start", exp_st.size(), 0);
    chk("pending_grad", exp_gv.size(), 0);
    chk("pending_fd", exp_fd.size(), 0);

    @(posedge clk); #1;
    model_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
